// File: rtl/temporizador_antirrebotes_pkg.sv
// Shared definitions for the debounce delay timer: FSM state encodings,
// default clock frequency and the ceiling-log2 helper used for counter widths.
package temporizador_antirrebotes_pkg;

  localparam int DEF_CLK_HZ = 100_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_HOLD = 2'd3
  } estado_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/temporizador_antirrebotes_generador_tick_ms.sv
// Cycle prescaler: counts 0..PRESC-1 while enabled and flags the last count
// as the 1 ms tick. Clear wins over enable.
module generador_tick_ms #(
  parameter int PRESC = 10,
  parameter int W     = 4
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [W-1:0] PRESC_LAST = W'(PRESC - 1);

  logic [W-1:0] presc_q;

  // Prescaler register, wraps at PRESC-1 so it never exceeds that bound
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      presc_q <= '0;
    end else if (clear) begin
      presc_q <= '0;
    end else if (enable) begin
      if (presc_q == PRESC_LAST) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + W'(1);
      end
    end else begin
      presc_q <= presc_q;
    end
  end

  assign tick = (presc_q == PRESC_LAST);

endmodule

// File: rtl/temporizador_antirrebotes.sv
// Debounce delay timer: counts DELAY_MS milliseconds while actCuenta is held
// and emits a single one-cycle t300ms pulse, then waits for actCuenta to drop.
module temporizador_antirrebotes
  import temporizador_antirrebotes_pkg::*;
#(
  parameter int CLK_HZ   = DEF_CLK_HZ,
  parameter int DELAY_MS = 300
) (
  input  logic                              Clk,
  input  logic                              Reset_n,
  input  logic                              actCuenta,
  output logic                              t300ms,
  output logic                              busy,
  output logic [clog2(DELAY_MS + 1) - 1:0]  ms_elapsed
);

  localparam int PRESC   = CLK_HZ / 1000;
  localparam int PRESC_W = clog2(PRESC);
  localparam int CNT_W   = (PRESC_W < 1) ? 1 : PRESC_W;
  localparam int MS_W    = clog2(DELAY_MS + 1);

  localparam logic [MS_W-1:0] MS_LAST = MS_W'(DELAY_MS - 1);
  localparam logic [MS_W-1:0] MS_DONE = MS_W'(DELAY_MS);

  if (((CLK_HZ % 1000) != 0) || (DELAY_MS < 1)) begin : g_param_check
    $error("temporizador_antirrebotes: CLK_HZ must be a multiple of 1000 and DELAY_MS >= 1");
  end

  estado_e         state_q;
  logic [MS_W-1:0] ms_q;
  logic            busy_q;
  logic            t300ms_q;
  logic            tick_s;
  logic            presc_clear_s;
  logic            presc_en_s;

  // The prescaler only runs in RUN; an abort clears it on the same edge
  assign presc_en_s    = (state_q == ST_RUN);
  assign presc_clear_s = (state_q != ST_RUN) || !actCuenta;

  generador_tick_ms #(
    .PRESC (PRESC),
    .W     (CNT_W)
  ) u_tick (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clear   (presc_clear_s),
    .enable  (presc_en_s),
    .tick    (tick_s)
  );

  // Control FSM with the ms counter and registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      ms_q     <= '0;
      busy_q   <= 1'b0;
      t300ms_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ms_q     <= '0;
          t300ms_q <= 1'b0;
          if (actCuenta) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          // Abort is checked first so a drop on the final tick yields no pulse
          if (!actCuenta) begin
            state_q  <= ST_IDLE;
            ms_q     <= '0;
            busy_q   <= 1'b0;
            t300ms_q <= 1'b0;
          end else if (tick_s && (ms_q == MS_LAST)) begin
            state_q  <= ST_DONE;
            ms_q     <= MS_DONE;
            busy_q   <= 1'b0;
            t300ms_q <= 1'b1;
          end else if (tick_s) begin
            state_q  <= ST_RUN;
            ms_q     <= ms_q + MS_W'(1);
            busy_q   <= 1'b1;
            t300ms_q <= 1'b0;
          end else begin
            state_q  <= ST_RUN;
            ms_q     <= ms_q;
            busy_q   <= 1'b1;
            t300ms_q <= 1'b0;
          end
        end
        ST_DONE: begin
          busy_q   <= 1'b0;
          t300ms_q <= 1'b0;
          if (actCuenta) begin
            state_q <= ST_HOLD;
            ms_q    <= ms_q;
          end else begin
            state_q <= ST_IDLE;
            ms_q    <= '0;
          end
        end
        ST_HOLD: begin
          busy_q   <= 1'b0;
          t300ms_q <= 1'b0;
          if (!actCuenta) begin
            state_q <= ST_IDLE;
            ms_q    <= '0;
          end else begin
            state_q <= ST_HOLD;
            ms_q    <= ms_q;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          ms_q     <= '0;
          busy_q   <= 1'b0;
          t300ms_q <= 1'b0;
        end
      endcase
    end
  end

  assign t300ms     = t300ms_q;
  assign busy       = busy_q;
  assign ms_elapsed = ms_q;

endmodule

// File: tb/tb_temporizador_antirrebotes.sv
// Self-checking bench: directed scenarios plus random actCuenta segments,
// compared each cycle against a run-length model of the timer.
module tb_temporizador_antirrebotes;

  localparam int CLK_HZ   = 10_000;
  localparam int DELAY_MS = 3;
  localparam int PRESC    = CLK_HZ / 1000;
  localparam int N        = DELAY_MS * PRESC;

  logic       Clk;
  logic       Reset_n;
  logic       actCuenta;
  logic       t300ms;
  logic       busy;
  logic [1:0] ms_elapsed;

  int errors;
  int checks;
  int run_len;
  int pulses;
  int pulses_before;

  temporizador_antirrebotes #(
    .CLK_HZ   (CLK_HZ),
    .DELAY_MS (DELAY_MS)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .actCuenta  (actCuenta),
    .t300ms     (t300ms),
    .busy       (busy),
    .ms_elapsed (ms_elapsed)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // run_len = consecutive sampled edges with actCuenta high since the last low/reset
  task automatic check_model(input string tag);
    int ms_exp;
    ms_exp = (run_len == 0) ? 0 : (run_len - 1) / PRESC;
    if (ms_exp > DELAY_MS) ms_exp = DELAY_MS;
    chk({tag, "_busy"}, 32'(busy), 32'((run_len >= 1) && (run_len <= N)));
    chk({tag, "_t300"}, 32'(t300ms), 32'(run_len == N + 1));
    chk({tag, "_ms"}, 32'(ms_elapsed), 32'(ms_exp));
  endtask

  task automatic step(input logic a, input string tag);
    actCuenta = a;
    @(posedge Clk);
    if (a) begin
      if (run_len < N + 2) run_len++;
    end else begin
      run_len = 0;
    end
    #1;
    if (t300ms === 1'b1) pulses++;
    check_model(tag);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    run_len   = 0;
    pulses    = 0;
    Reset_n   = 1'b1;
    actCuenta = 1'b0;

    #2 Reset_n = 1'b0;
    #1;
    check_model("reset");
    repeat (2) @(posedge Clk);
    #1;
    check_model("reset_hold");
    Reset_n = 1'b1;

    // 1: full run with the pulse at edge 30
    for (int i = 0; i < 32; i++) step(1'b1, "s1");

    // 2: stay in HOLD, then a fresh rise restarts the delay
    pulses_before = pulses;
    for (int i = 0; i < 100; i++) step(1'b1, "s2_hold");
    chk("s2_no_repulse", 32'(pulses - pulses_before), 32'd0);
    step(1'b0, "s2");
    for (int i = 0; i < 31; i++) step(1'b1, "s2_rerun");
    chk("s2_one_pulse", 32'(pulses - pulses_before), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, "s2_idle");

    // 3: abort at edge 15, re-raise at edge 20
    for (int i = 0; i < 15; i++) step(1'b1, "s3_run");
    for (int i = 0; i < 5; i++) step(1'b0, "s3_abort");
    for (int i = 0; i < 32; i++) step(1'b1, "s3_rerun");
    for (int i = 0; i < 2; i++) step(1'b0, "s3_idle");

    // 4: drop on the final tick edge suppresses the pulse
    pulses_before = pulses;
    for (int i = 0; i < 30; i++) step(1'b1, "s4_run");
    step(1'b0, "s4_drop");
    step(1'b0, "s4_idle");
    chk("s4_no_pulse", 32'(pulses - pulses_before), 32'd0);

    // 5: asynchronous reset in the middle of a run
    for (int i = 0; i < 25; i++) step(1'b1, "s5_run");
    #3 Reset_n = 1'b0;
    #1;
    run_len = 0;
    chk("s5_async_busy", 32'(busy), 32'd0);
    chk("s5_async_ms", 32'(ms_elapsed), 32'd0);
    chk("s5_async_t300", 32'(t300ms), 32'd0);
    @(posedge Clk);
    #1;
    check_model("s5_in_reset");
    Reset_n = 1'b1;
    for (int i = 0; i < 33; i++) step(1'b1, "s5_rerun");
    step(1'b0, "s5_idle");

    // 6: bouncy press then steady press gives exactly one pulse
    pulses_before = pulses;
    step(1'b1, "s6_bounce");
    step(1'b0, "s6_bounce");
    step(1'b1, "s6_bounce");
    step(1'b0, "s6_bounce");
    step(1'b1, "s6_bounce");
    for (int i = 0; i < 60; i++) step(1'b1, "s6_press");
    for (int i = 0; i < 3; i++) step(1'b0, "s6_release");
    chk("s6_one_pulse", 32'(pulses - pulses_before), 32'd1);

    // Random segments of actCuenta, lengths clustered around the delay
    for (int s = 0; s < 60; s++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       len = $urandom_range(1, 5);
        1:       len = $urandom_range(N - 2, N + 3);
        2:       len = $urandom_range(N + 4, N + 20);
        default: len = $urandom_range(1, N);
      endcase
      for (int i = 0; i < len; i++) step(lvl, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
